// File: rtl/s2c_bcd_conv_if.sv
// Handshake and result bundle between the result producer, the BCD converter
// and the seven-segment digit multiplexer.
interface s2c_bcd_conv_if #(
  parameter int W  = 10,
  parameter int ND = 3
) ();
  logic                start;
  logic signed [W-1:0] value;
  logic                ovf_in;
  logic                busy;
  logic                done;
  logic                neg;
  logic [4*ND-1:0]     bcd;
  logic                err;
  logic [ND-1:0]       blank;

  modport master (
    output start, value, ovf_in,
    input  busy, done, neg, bcd, err, blank
  );

  modport slave (
    input  start, value, ovf_in,
    output busy, done, neg, bcd, err, blank
  );
endinterface

// File: rtl/s2c_bcd_conv.sv
// Two's-complement to sign + packed BCD converter, iterative double dabble.
// Optional leading-zero blank mask enabled with `define S2C_BCD_BLANK_EN.
module s2c_bcd_conv #(
  parameter int W  = 10,
  parameter int ND = 3
) (
  input logic           clk,
  input logic           reset,
  s2c_bcd_conv_if.slave bus
);
  localparam int CNT_W = $clog2(W + 1);
  localparam int BW    = 4 * ND;
  localparam logic [W-1:0]     ONE   = W'(1);
  localparam logic [CNT_W-1:0] CNT_1 = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ABS, SHIFT, DONE} state_t;

  state_t              state, state_n;
  logic signed [W-1:0] val_cap;
  logic                ovf_cap;
  logic [W-1:0]        mag;
  logic [BW-1:0]       scratch;
  logic [BW-1:0]       scratch_adj;
  logic [CNT_W-1:0]    cnt;

  logic                busy_r;
  logic                done_r;
  logic                neg_r;
  logic                err_r;
  logic [BW-1:0]       bcd_r;

  // Magnitude kept in W unsigned bits, so the most negative input maps to 2^(W-1).
  function automatic logic [W-1:0] abs_mag(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = v;
    return u[W-1] ? (~u + ONE) : u;
  endfunction

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] s);
    logic [BW-1:0] r;
    r = s;
    for (int i = 0; i < ND; i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef S2C_BCD_BLANK_EN
  // Digit 0 is never blanked so a zero result still shows one "0".
  function automatic logic [ND-1:0] blank_mask(input logic [BW-1:0] d);
    logic [ND-1:0] m;
    logic          zero_above;
    m          = '0;
    zero_above = 1'b1;
    for (int i = ND - 1; i >= 1; i--) begin
      zero_above = zero_above && (d[4*i +: 4] == 4'd0);
      m[i]       = zero_above;
    end
    return m;
  endfunction

  logic [ND-1:0] blank_r;
`endif

  assign scratch_adj = add3(scratch);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.start) state_n = ABS;
      ABS:     state_n = SHIFT;
      SHIFT:   if (cnt == CNT_1) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_cap <= '0;
      ovf_cap <= 1'b0;
      mag     <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      neg_r   <= 1'b0;
      err_r   <= 1'b0;
      bcd_r   <= '0;
`ifdef S2C_BCD_BLANK_EN
      blank_r <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            val_cap <= bus.value;
            ovf_cap <= bus.ovf_in;
            busy_r  <= 1'b1;
          end
        end
        ABS: begin
          mag     <= abs_mag(val_cap);
          scratch <= '0;
          cnt     <= CNT_W'(W);
        end
        SHIFT: begin
          // Correction is applied before the shift in the same cycle.
          scratch <= {scratch_adj[BW-2:0], mag[W-1]};
          mag     <= {mag[W-2:0], 1'b0};
          cnt     <= cnt - CNT_1;
        end
        DONE: begin
          bcd_r   <= scratch;
          neg_r   <= val_cap[W-1];
          err_r   <= ovf_cap;
`ifdef S2C_BCD_BLANK_EN
          blank_r <= blank_mask(scratch);
`endif
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.neg  = neg_r;
  assign bus.err  = err_r;
  assign bus.bcd  = bcd_r;
`ifdef S2C_BCD_BLANK_EN
  assign bus.blank = blank_r;
`else
  assign bus.blank = '0;
`endif

endmodule

// File: doc/s2c_bcd_conv.md
# s2c_bcd_conv

Sequential converter that turns a W-bit two's-complement value, such as the result of the adder/subtractor stage, into a sign flag plus packed BCD digits for the decimal display. The conversion is iterative shift-add-3 (double dabble), one magnitude bit per clock. A start/busy/done handshake connects it to the result producer upstream. Registered outputs drive the seven-segment digit multiplexer downstream.

## Interface
- W, 10: input width in bits, two's complement; legal 2..16
- ND, 3: number of BCD digits; must satisfy 10^ND > 2^(W-1); default covers -512..511
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- value  input  W  signed operand, captured on the accepted start
- ovf_in  input  1  upstream overflow flag, captured with value
- busy  output  1  conversion in progress
- done  output  1  one-cycle pulse when new outputs are valid
- neg  output  1  sign of the captured value (1 = negative)
- bcd  output  4*ND  magnitude digits, bcd[3:0] = ones, bcd[7:4] = tens, and so on
- err  output  1  captured ovf_in, registered alongside bcd
- blank  output  ND  leading-zero blank mask, bit i for digit i (see Configuration)

## Operation
- Reset values: all outputs 0, including busy, done, neg, bcd, err and blank. The FSM is in IDLE. Internal shift and scratch registers are cleared.
- States: IDLE → ABS → SHIFT → DONE → IDLE.
- IDLE: start=1 captures value and ovf_in, sets busy=1, and moves to ABS.
- ABS: mag = value[W-1] ? (~value + 1) : value, computed in W bits without sign extension. The most negative value (e.g. 10'h200) gives an unsigned magnitude of 512. This is correct because mag is treated as unsigned. The BCD scratch register is cleared and the bit counter loads W.
- SHIFT: each cycle does two things.
  - Every 4-bit scratch digit ≥ 5 gets +3.
  - Then {scratch, mag} shifts left by 1 and the counter decrements.
  - After W shifts, the FSM moves to DONE.
- DONE:
  - bcd ← scratch, neg ← captured sign, err ← captured ovf_in, blank ← computed mask.
  - done=1 for this single cycle and busy=0. The FSM returns to IDLE.
- neg is never 1 with a magnitude of 0.
- start while busy=1 is ignored: no capture, no restart, no queueing.
- start asserted in the cycle after DONE (busy=0) is accepted normally, giving back-to-back conversions.
- bcd, neg, err and blank hold their last values until the next DONE. They do not change during a conversion.
- reset asserted mid-conversion aborts immediately. All outputs and state return to reset values, and no done pulse is produced.

## Timing
- Edge E0 samples start=1 with busy=0. busy is high from after E0.
- E1 performs ABS. Edges E2..E(W+1) perform the W shifts.
- E(W+2) registers the outputs. done is high and busy is low for the following cycle.
- Latency from the start-sampling edge to outputs valid is W+2 edges (12 for W=10).
- Maximum throughput is one conversion per W+3 cycles.
- Digit add-3 correction is combinational ahead of the shift register. There is no extra cycle per digit.

## Configuration
- Macro S2C_BCD_BLANK_EN controls leading-zero blanking.
- Defined:
  - blank[i]=1 when digit i and all higher digits are 0, for i ≥ 1.
  - blank[0] is always 0, so a zero result shows a single "0".
  - blank is registered in DONE with bcd.
- Undefined: blank is tied to all zeros. There is no mask logic, and the port stays present so the interface is identical.

## Test plan
- value=10'd0 → after 12 edges: done pulse, neg=0, bcd=12'h000, err=0; with S2C_BCD_BLANK_EN, blank=3'b110.
- value=10'd511 → neg=0, bcd=12'h511. value=10'h3FF (−1) → neg=1, bcd=12'h001; with the macro, blank=3'b110.
- value=10'h200 (−512), ovf_in=1 → neg=1, bcd=12'h512, err=1, blank=3'b000.
- Start −37 (10'h3DB), then pulse start with value=10'd99 during busy → single done, neg=1, bcd=12'h037. Issue a start in the done cycle → next result bcd=12'h099 after 12 edges.
- Assert reset at edge E5 of a conversion of 10'd300 → busy, done, neg and bcd go to 0 at once, and no done pulse follows.
- Sweep all 1024 values of W=10 against a reference model → sign and digits match, and every done pulse is exactly one cycle, 12 edges after its start.
